// File: rtl/drp_responder.sv
// DRP target for the MMCM reconfiguration port: a 128 x 16 register bank with fixed-latency DRDY,
// a modelled RST/LOCKED sequence and sticky protocol-misuse flags.
module drp_responder #(
  parameter int pLATENCY     = 3,
  parameter int pLOCK_CYCLES = 64
) (
  input  logic        clk_usb,
  input  logic        reset_n,
  input  logic [6:0]  drp_addr,
  input  logic        drp_den,
  input  logic        drp_dwe,
  input  logic [15:0] drp_din,
  output logic [15:0] drp_dout,
  output logic        drp_drdy,
  input  logic        drp_reset,
  output logic        locked,
  output logic        busy,
  output logic        err_overlap,
  output logic        err_unsafe_wr,
  input  logic        err_clear
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0]  LAT_M1      = 4'(pLATENCY - 1);
  localparam logic [15:0] LOCK_TARGET = 16'(pLOCK_CYCLES);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [6:0]  addr_r;
  logic [15:0] din_r;
  logic        dwe_r;
  logic [15:0] bank_r [0:127];
  logic [15:0] dout_r;
  logic        drdy_r;
  logic        busy_r;
  logic        ovl_r;
  logic        unsafe_r;
  logic [15:0] lock_cnt_r;
  logic        locked_r;
  logic        accept_s;
  logic        done_s;
  logic        ovl_set_s;
  logic        unsafe_set_s;

  // Next-state and per-cycle strobes of the request FSM.
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (drp_den) begin
          accept_s = 1'b1;
          state_s  = (pLATENCY == 1) ? ST_DONE : ST_WAIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    done_s       = (state_r == ST_DONE);
    ovl_set_s    = drp_den && (state_r != ST_IDLE);
    unsafe_set_s = done_s && dwe_r && !drp_reset;
  end

  // State register, latency counter and request latch.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 7'd0;
      din_r   <= 16'd0;
      dwe_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      if (accept_s) begin
        addr_r <= drp_addr;
        din_r  <= drp_din;
        dwe_r  <= drp_dwe;
        cnt_r  <= LAT_M1;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Bank access at completion; a read samples the bank as it stands in the DONE cycle.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 128; i++) begin
        bank_r[i] <= 16'd0;
      end
      dout_r <= 16'd0;
      drdy_r <= 1'b0;
    end else begin
      drdy_r <= done_s;
      if (done_s) begin
        if (dwe_r) begin
          bank_r[addr_r] <= din_r;
        end else begin
          dout_r <= bank_r[addr_r];
        end
      end
    end
  end

  // Sticky error flags; a set in the same cycle as err_clear takes priority.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      ovl_r    <= 1'b0;
      unsafe_r <= 1'b0;
    end else begin
      if (ovl_set_s) begin
        ovl_r <= 1'b1;
      end else if (err_clear) begin
        ovl_r <= 1'b0;
      end
      if (unsafe_set_s) begin
        unsafe_r <= 1'b1;
      end else if (err_clear) begin
        unsafe_r <= 1'b0;
      end
    end
  end

  // Lock model: counting to the target first and flagging on the following edge places
  // LOCKED exactly pLOCK_CYCLES edges after the first counting edge.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt_r <= 16'd0;
      locked_r   <= 1'b0;
    end else if (drp_reset) begin
      lock_cnt_r <= 16'd0;
      locked_r   <= 1'b0;
    end else if (!locked_r) begin
      if (lock_cnt_r == LOCK_TARGET) begin
        locked_r <= 1'b1;
      end else begin
        lock_cnt_r <= lock_cnt_r + 16'd1;
      end
    end
  end

  assign drp_dout      = dout_r;
  assign drp_drdy      = drdy_r;
  assign busy          = busy_r;
  assign locked        = locked_r;
  assign err_overlap   = ovl_r;
  assign err_unsafe_wr = unsafe_r;

endmodule

// File: tb/tb_drp_responder.sv
// Directed bench for drp_responder: a vector table for single transactions plus hand-written
// sequences for lock timing, overlap, reset abort and a pLATENCY=1 back-to-back sweep.
module tb_drp_responder;

  logic        clk_usb;
  logic        reset_n;
  logic [6:0]  drp_addr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_din;
  logic [15:0] drp_dout;
  logic        drp_drdy;
  logic        drp_reset;
  logic        locked;
  logic        busy;
  logic        err_overlap;
  logic        err_unsafe_wr;
  logic        err_clear;

  logic [6:0]  l1_addr;
  logic        l1_den;
  logic        l1_dwe;
  logic [15:0] l1_din;
  logic [15:0] l1_dout;
  logic        l1_drdy;
  logic        l1_reset;
  logic        l1_locked;
  logic        l1_busy;
  logic        l1_err_overlap;
  logic        l1_err_unsafe_wr;
  logic        l1_err_clear;

  int n_vec;
  int n_err;

  typedef struct packed {
    logic        rst;
    logic        dwe;
    logic [6:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_unsafe;
  } vec_t;

  vec_t vecs [0:7];

  drp_responder #(.pLATENCY(3), .pLOCK_CYCLES(64)) u_dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .drp_addr(drp_addr), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_din(drp_din), .drp_dout(drp_dout), .drp_drdy(drp_drdy),
    .drp_reset(drp_reset), .locked(locked), .busy(busy), .err_overlap(err_overlap),
    .err_unsafe_wr(err_unsafe_wr), .err_clear(err_clear)
  );

  drp_responder #(.pLATENCY(1), .pLOCK_CYCLES(64)) u_lat1 (
    .clk_usb(clk_usb), .reset_n(reset_n), .drp_addr(l1_addr), .drp_den(l1_den),
    .drp_dwe(l1_dwe), .drp_din(l1_din), .drp_dout(l1_dout), .drp_drdy(l1_drdy),
    .drp_reset(l1_reset), .locked(l1_locked), .busy(l1_busy), .err_overlap(l1_err_overlap),
    .err_unsafe_wr(l1_err_unsafe_wr), .err_clear(l1_err_clear)
  );

  initial clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  // One request on the pLATENCY=3 instance; the den is sampled at the first edge.
  task automatic do_txn(input string name, input logic dwe, input logic [6:0] addr,
                        input logic [15:0] din, input logic [15:0] exp_dout,
                        input logic exp_unsafe);
    int cyc;
    cyc = 0;
    drp_addr = addr;
    drp_din  = din;
    drp_dwe  = dwe;
    drp_den  = 1'b1;
    tick();
    drp_den  = 1'b0;
    do begin
      tick();
      cyc++;
    end while (!drp_drdy && cyc < 20);
    chk({name, "_latency"}, 32'(cyc), 32'd3);
    chk({name, "_dout"}, 32'(drp_dout), 32'(exp_dout));
    chk({name, "_unsafe"}, 32'(err_unsafe_wr), 32'(exp_unsafe));
    tick();
    chk({name, "_drdy_pulse"}, 32'(drp_drdy), 32'd0);
  endtask

  // Called right after reset release: LOCKED must stay low through edge 63 and rise at edge 64.
  task automatic lock_check(input string name);
    int n_drdy;
    n_drdy = 0;
    for (int k = 0; k <= 64; k++) begin
      tick();
      if (drp_drdy) n_drdy++;
      if (k == 63) chk({name, "_locked_e63"}, 32'(locked), 32'd0);
      if (k == 64) chk({name, "_locked_e64"}, 32'(locked), 32'd1);
    end
    chk({name, "_no_drdy"}, 32'(n_drdy), 32'd0);
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 517) ^ 16'h3C3C;
  endfunction

  initial begin
    int n_drdy;
    n_vec = 0;
    n_err = 0;

    vecs[0] = '{1'b1, 1'b1, 7'h28, 16'hA5C3, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 7'h28, 16'h0000, 16'hA5C3, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 7'h7F, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 7'h7F, 16'h1234, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 7'h7F, 16'h0000, 16'h1234, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 7'h00, 16'hFFFF, 16'h1234, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 7'h00, 16'h0000, 16'hFFFF, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 7'h28, 16'h0000, 16'hA5C3, 1'b1};

    reset_n = 1'b0; drp_addr = 7'd0; drp_den = 1'b0; drp_dwe = 1'b0; drp_din = 16'd0;
    drp_reset = 1'b0; err_clear = 1'b0;
    l1_addr = 7'd0; l1_den = 1'b0; l1_dwe = 1'b0; l1_din = 16'd0;
    l1_reset = 1'b1; l1_err_clear = 1'b0;

    // Reset values, then lock acquisition from the first edge after release.
    tick();
    tick();
    chk("rst_dout", 32'(drp_dout), 32'd0);
    chk("rst_drdy", 32'(drp_drdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ovl", 32'(err_overlap), 32'd0);
    chk("rst_unsafe", 32'(err_unsafe_wr), 32'd0);
    reset_n = 1'b1;
    lock_check("init");
    chk("idle_dout", 32'(drp_dout), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ovl", 32'(err_overlap), 32'd0);
    chk("idle_unsafe", 32'(err_unsafe_wr), 32'd0);

    // Table of single transactions.
    for (int i = 0; i < 8; i++) begin
      drp_reset = vecs[i].rst;
      tick();
      if (vecs[i].rst) chk($sformatf("vec%0d_locked_drop", i), 32'(locked), 32'd0);
      do_txn($sformatf("vec%0d", i), vecs[i].dwe, vecs[i].addr, vecs[i].din,
             vecs[i].exp_dout, vecs[i].exp_unsafe);
    end

    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("unsafe_cleared", 32'(err_unsafe_wr), 32'd0);

    // Overlapping den at edge 2 is ignored and flagged.
    drp_reset = 1'b1;
    chk("ovl_before", 32'(err_overlap), 32'd0);
    drp_addr = 7'h01; drp_din = 16'h1111; drp_dwe = 1'b1; drp_den = 1'b1;
    tick();
    drp_den = 1'b0;
    tick();
    chk("ovl_busy", 32'(busy), 32'd1);
    drp_din = 16'h2222; drp_den = 1'b1;
    tick();
    drp_den = 1'b0;
    n_drdy = 0;
    for (int k = 3; k <= 10; k++) begin
      tick();
      if (drp_drdy) n_drdy++;
    end
    chk("ovl_one_drdy", 32'(n_drdy), 32'd1);
    chk("ovl_flag", 32'(err_overlap), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ovl_cleared", 32'(err_overlap), 32'd0);
    do_txn("ovl_readback", 1'b0, 7'h01, 16'h0000, 16'h1111, 1'b0);

    // Overlap set coinciding with err_clear: set wins.
    drp_addr = 7'h01; drp_dwe = 1'b0; drp_den = 1'b1;
    tick();
    drp_den = 1'b0;
    tick();
    drp_den = 1'b1; err_clear = 1'b1;
    tick();
    drp_den = 1'b0; err_clear = 1'b0;
    chk("ovl_set_wins", 32'(err_overlap), 32'd1);
    repeat (4) tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ovl_cleared2", 32'(err_overlap), 32'd0);

    // Reset asserted mid-transaction aborts the write and the drdy.
    drp_reset = 1'b0;
    drp_addr = 7'h05; drp_din = 16'hBEEF; drp_dwe = 1'b1; drp_den = 1'b1;
    tick();
    drp_den = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("abort_drdy", 32'(drp_drdy), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_locked", 32'(locked), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    lock_check("relock");
    do_txn("abort_rd05", 1'b0, 7'h05, 16'h0000, 16'h0000, 1'b0);
    do_txn("abort_rd28", 1'b0, 7'h28, 16'h0000, 16'h0000, 1'b0);

    // pLATENCY=1: requests every two cycles across the whole bank.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 128; i++) begin
        l1_addr = 7'(i);
        l1_din  = pat(i);
        l1_dwe  = (pass == 0);
        l1_den  = 1'b1;
        tick();
        l1_den  = 1'b0;
        chk($sformatf("l1_p%0d_a%0d_early", pass, i), 32'(l1_drdy), 32'd0);
        tick();
        chk($sformatf("l1_p%0d_a%0d_drdy", pass, i), 32'(l1_drdy), 32'd1);
        if (pass == 1) chk($sformatf("l1_rd_a%0d_dout", i), 32'(l1_dout), 32'(pat(i)));
      end
    end
    tick();
    chk("l1_ovl", 32'(l1_err_overlap), 32'd0);
    chk("l1_unsafe", 32'(l1_err_unsafe_wr), 32'd0);
    chk("l1_busy_idle", 32'(l1_busy), 32'd0);
    chk("l1_locked_held", 32'(l1_locked), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
